// File: rtl/codec_i2c_sequencer.sv
// codec_i2c_sequencer: serialises {SubAddrL, data} codec commands into 3-byte I2C
// write frames (device address, sub-address, data), retrying after a NACK.
module codec_i2c_sequencer #(
   parameter logic [6:0] DEV_ADDR  = 7'h1A,
   parameter int         CLK_DIV   = 250,
   parameter int         MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       write,
   input  logic [7:0] SubAddrL,
   input  logic [7:0] data,
   output logic       NewCom,
   output logic       busy,
   output logic       ack_err,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_BIT   = 3'd2;
   localparam logic [2:0] S_ACK   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int                 RETRY_W   = $clog2(MAX_RETRY + 2);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   localparam logic [9:0]         DIV_LAST  = 10'(CLK_DIV - 1);

   logic [2:0]         state, nextState;
   logic [9:0]         divCnt, nextDivCnt;
   logic [1:0]         quarter, nextQuarter;
   logic [2:0]         bitIdx, nextBitIdx;
   logic [1:0]         byteIdx, nextByteIdx;
   logic [7:0]         shadowSub, shadowData;
   logic               loadShadow;
   logic [RETRY_W-1:0] retryCnt, nextRetryCnt;
   logic               attemptFailed, nextAttemptFailed;
   logic               ackSample, nextAckSample;
   logic               nextNewCom, nextBusy, nextAckErr;
   logic               frameActive, tick, slotEnd, retryLeft;
   logic [7:0]         nextByte;
   logic               nextBit;
   logic [1:0]         nextLevels;

   // Bus levels {scl, sda_oe} for a given slot and quarter.
   function automatic logic [1:0] busLevel(input logic [2:0] st, input logic [1:0] q,
                                           input logic b);
      logic [1:0] lv;
      case (st)
         S_START: lv = {1'b1, q[1]};
         S_BIT:   lv = {q[1], ~b};
         S_ACK:   lv = {q[1], 1'b0};
         S_STOP: begin
            if (q == 2'd0)      lv = 2'b01;
            else if (q == 2'd1) lv = 2'b11;
            else                lv = 2'b10;
         end
         default: lv = 2'b10;
      endcase
      return lv;
   endfunction

   assign frameActive = (state == S_START) || (state == S_BIT) ||
                        (state == S_ACK)   || (state == S_STOP);
   assign tick        = frameActive && (divCnt == DIV_LAST);
   assign slotEnd     = tick && (quarter == 2'd3);
   assign retryLeft   = (retryCnt < RETRY_MAX);

   always_comb begin
      nextState         = state;
      nextDivCnt        = divCnt;
      nextQuarter       = quarter;
      nextBitIdx        = bitIdx;
      nextByteIdx       = byteIdx;
      nextRetryCnt      = retryCnt;
      nextAttemptFailed = attemptFailed;
      nextAckSample     = ackSample;
      nextNewCom        = 1'b0;
      nextBusy          = busy;
      nextAckErr        = ack_err;
      loadShadow        = 1'b0;

      if (frameActive) begin
         nextDivCnt = tick ? 10'd0 : divCnt + 10'd1;
         if (tick) nextQuarter = quarter + 2'd1;
      end

      case (state)
         S_IDLE: begin
            if (write) begin
               loadShadow        = 1'b1;
               nextBusy          = 1'b1;
               nextState         = S_START;
               nextDivCnt        = 10'd0;
               nextQuarter       = 2'd0;
               nextByteIdx       = 2'd0;
               nextBitIdx        = 3'd7;
               nextAttemptFailed = 1'b0;
            end
         end
         S_START: begin
            if (slotEnd) begin
               nextState   = S_BIT;
               nextByteIdx = 2'd0;
               nextBitIdx  = 3'd7;
            end
         end
         S_BIT: begin
            if (slotEnd) begin
               if (bitIdx == 3'd0) nextState  = S_ACK;
               else                nextBitIdx = bitIdx - 3'd1;
            end
         end
         S_ACK: begin
            // The slave's answer is taken at the end of q2, mid scl-high.
            if (tick && quarter == 2'd2) nextAckSample = sda_in;
            if (slotEnd) begin
               if (ackSample) begin
                  nextState         = S_STOP;
                  nextAttemptFailed = 1'b1;
               end else if (byteIdx == 2'd2) begin
                  nextState = S_STOP;
               end else begin
                  nextState   = S_BIT;
                  nextByteIdx = byteIdx + 2'd1;
                  nextBitIdx  = 3'd7;
               end
            end
         end
         S_STOP: begin
            if (slotEnd) begin
               if (!attemptFailed) begin
                  nextState    = S_DONE;
                  nextNewCom   = 1'b1;
                  nextRetryCnt = '0;
               end else if (retryLeft) begin
                  nextState         = S_START;
                  nextRetryCnt      = retryCnt + 1'b1;
                  nextAttemptFailed = 1'b0;
                  nextByteIdx       = 2'd0;
                  nextBitIdx        = 3'd7;
               end else begin
                  nextState    = S_DONE;
                  nextNewCom   = 1'b1;
                  nextAckErr   = 1'b1;
                  nextRetryCnt = '0;
               end
            end
         end
         S_DONE: begin
            nextState   = S_IDLE;
            nextBusy    = 1'b0;
            nextDivCnt  = 10'd0;
            nextQuarter = 2'd0;
         end
         default: nextState = S_IDLE;
      endcase
   end

   // Outputs are registered from the upcoming slot/quarter so they move only on boundaries.
   always_comb begin
      case (nextByteIdx)
         2'd0:    nextByte = {DEV_ADDR, 1'b0};
         2'd1:    nextByte = shadowSub;
         default: nextByte = shadowData;
      endcase
      nextBit    = nextByte[nextBitIdx];
      nextLevels = busLevel(nextState, nextQuarter, nextBit);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         divCnt        <= 10'd0;
         quarter       <= 2'd0;
         bitIdx        <= 3'd7;
         byteIdx       <= 2'd0;
         retryCnt      <= '0;
         attemptFailed <= 1'b0;
         ackSample     <= 1'b0;
         NewCom        <= 1'b0;
         busy          <= 1'b0;
         ack_err       <= 1'b0;
         scl           <= 1'b1;
         sda_oe        <= 1'b0;
      end else begin
         state         <= nextState;
         divCnt        <= nextDivCnt;
         quarter       <= nextQuarter;
         bitIdx        <= nextBitIdx;
         byteIdx       <= nextByteIdx;
         retryCnt      <= nextRetryCnt;
         attemptFailed <= nextAttemptFailed;
         ackSample     <= nextAckSample;
         NewCom        <= nextNewCom;
         busy          <= nextBusy;
         ack_err       <= nextAckErr;
         scl           <= nextLevels[1];
         sda_oe        <= nextLevels[0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadowSub  <= 8'h00;
         shadowData <= 8'h00;
      end else if (loadShadow) begin
         shadowSub  <= SubAddrL;
         shadowData <= data;
      end
   end

endmodule

// File: doc/codec_i2c_sequencer.md
Name: codec_i2c_sequencer

Overview:
- Serial-bus master that sequences codec register configuration.
- Accepts one {SubAddrL, data} command per write strobe from the codec command table and serializes it as a 3-byte I2C write frame: device address, sub-address, data.
- Pulses NewCom when the frame has completed, which advances the table to the next command.
- Sits between the codec setup table and the codec's SCL/SDA pins.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit codec device address; R/W bit is always 0.
- CLK_DIV, 250, clk cycles per SCL quarter-period; legal range 2..1023.
- MAX_RETRY, 3, extra attempts made after a NACK before the command is abandoned.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- write  input  1  command strobe, sampled only in IDLE
- SubAddrL  input  8  register sub-address
- data  input  8  register data
- NewCom  output  1  one-cycle pulse: frame finished, next command requested
- busy  output  1  high from command accept until the NewCom pulse (inclusive)
- ack_err  output  1  sticky; set when a command is abandoned after retries
- scl  output  1  bus clock, push-pull
- sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain)
- sda_in  input  1  sampled SDA line

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE, scl = 1, sda_oe = 0, NewCom = 0, busy = 0, ack_err = 0;
  - quarter counter = 0, retry counter = 0.
- Quarter tick: a divider counts 0..CLK_DIV-1 and ticks on the wrap. Every slot is 4 quarters, q0..q3.
- IDLE:
  - write = 1 latches SubAddrL and data into shadow registers, sets busy and enters START on the next clk.
  - Inputs are ignored while busy.
- START slot:
  - q0–q1: scl = 1, SDA released.
  - q2–q3: scl = 1, SDA low.
- BIT slot, MSB first; bytes are {DEV_ADDR,0}, SubAddrL, data:
  - q0–q1: scl = 0, sda_oe = ~bit.
  - q2–q3: scl = 1.
- ACK slot (after each byte):
  - SDA is released for all 4 quarters; scl follows the BIT slot pattern.
  - sda_in is sampled at the end of q2.
  - 0 = ACK: continue with the next byte.
  - 1 = NACK: go to STOP, marking the attempt as failed.
- STOP slot:
  - q0: scl = 0, SDA low.
  - q1: scl = 1, SDA low.
  - q2–q3: scl = 1, SDA released.
- Frame length: 1 START + 27 data/ACK slots + 1 STOP = 29 slots = 116 quarters = 116*CLK_DIV clk.
- DONE, entered after STOP q3 ends:
  - Success: NewCom = 1 for exactly one clk; busy drops the clk after; retry counter cleared; → IDLE.
  - Failed, retry < MAX_RETRY: retry++, restart at START with the same latched bytes. No NewCom.
  - Failed, retry = MAX_RETRY: set ack_err; pulse NewCom so configuration proceeds; clear retry; → IDLE.
- write asserted in the same clk as the NewCom pulse is ignored; it is accepted from the next clk in IDLE.
- The shadow registers are stable for the whole frame. Input changes during busy have no effect.
- scl/sda_oe change only on quarter boundaries. They are registered outputs with no glitches.
- Reset mid-frame aborts immediately. The bus returns to idle levels (scl = 1, SDA released) with no STOP generated.

Test Plan:
- CLK_DIV=2, write with SubAddrL=8'h0C, data=8'h5A, bench ACKs every byte:
  - scl shows 27 high pulses;
  - SDA bit stream = 0011_0100 A 0000_1100 A 0101_1010 A;
  - NewCom pulses once, 232 clk after accept; busy high throughout.
- START/STOP edges: SDA falls while scl=1 at the start and rises while scl=1 at the end; no other SDA transition occurs while scl=1.
- NACK on the data byte in every attempt, MAX_RETRY=3:
  - exactly 4 frames;
  - then ack_err=1 and a single NewCom pulse;
  - ack_err stays 1 until reset.
- NACK on the first attempt only: 2 frames, one NewCom, ack_err=0.
- write pulses plus SubAddrL/data changes mid-frame: transmitted bytes are unchanged and no second frame starts.
- 30 back-to-back commands with write fed from NewCom delayed 8 clk: 30 frames, 30 NewCom pulses.
- Reset asserted mid-bit: outputs are at reset values in the same cycle; a new command afterwards runs a full, correct frame.
